// File: rtl/l2_global_pkg.sv
// Shared types, derived widths and helpers for the L2 global-state register bank.
package l2_global_pkg;

  localparam int N_MSHR_DEF  = 16;
  localparam int L2_SETS_DEF = 256;
  localparam int L2_WAYS_DEF = 8;

  function automatic int bits_min1(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // A set strobe loses to a clear strobe arriving in the same cycle.
  function automatic logic sc_next(input logic q, input logic set_s, input logic clr_s);
    if (clr_s) begin
      return 1'b0;
    end else if (set_s) begin
      return 1'b1;
    end else begin
      return q;
    end
  endfunction

  localparam int MSHR_BITS = bits_min1(N_MSHR_DEF);
  localparam int SET_BITS  = bits_min1(L2_SETS_DEF);
  localparam int WAY_BITS  = bits_min1(L2_WAYS_DEF);

  typedef enum logic [1:0] {
    FLUSH_IDLE = 2'd0,
    FLUSH_WALK = 2'd1,
    FLUSH_DONE = 2'd2
  } flush_state_t;

endpackage

// File: rtl/l2_global_regs_walker.sv
// Set/way flush walker: visits every (set, way) pair once per flush,
// then pulses flush_done for one cycle.
module l2_flush_walker
  import l2_global_pkg::*;
#(
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8,
  localparam int SET_W = bits_min1(L2_SETS),
  localparam int WAY_W = bits_min1(L2_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_start,
  input  logic             flush_step,
  input  logic             flush_abort,
  output logic [SET_W-1:0] flush_set,
  output logic [WAY_W-1:0] flush_way,
  output logic             ongoing_flush,
  output logic             flush_done
);

  localparam int SET_LAST_I = L2_SETS - 1;
  localparam int WAY_LAST_I = L2_WAYS - 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_LAST_I[SET_W-1:0];
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_LAST_I[WAY_W-1:0];
  localparam logic [SET_W-1:0] SET_ONE  = {{(SET_W-1){1'b0}}, 1'b1};
  localparam logic [WAY_W-1:0] WAY_ONE  = {{(WAY_W-1){1'b0}}, 1'b1};

  flush_state_t     state_d, state_q;
  logic [SET_W-1:0] set_d, set_q;
  logic [WAY_W-1:0] way_d, way_q;
  logic             done_d, done_q;
  logic             ongoing_d, ongoing_q;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    case (state_q)
      FLUSH_IDLE: begin
        set_d = '0;
        way_d = '0;
        if (flush_start) begin
          state_d = FLUSH_WALK;
        end else begin
          state_d = FLUSH_IDLE;
        end
      end
      FLUSH_WALK: begin
        if (flush_abort) begin
          state_d = FLUSH_IDLE;
          set_d   = '0;
          way_d   = '0;
        end else if (flush_step) begin
          if (way_q != WAY_LAST) begin
            way_d = way_q + WAY_ONE;
          end else begin
            way_d = '0;
            // Last way of the last set ends the walk; counters park at zero.
            if (set_q != SET_LAST) begin
              set_d = set_q + SET_ONE;
            end else begin
              set_d   = '0;
              state_d = FLUSH_DONE;
            end
          end
        end else begin
          state_d = FLUSH_WALK;
        end
      end
      FLUSH_DONE: begin
        state_d = FLUSH_IDLE;
        set_d   = '0;
        way_d   = '0;
      end
      default: begin
        state_d = FLUSH_IDLE;
        set_d   = '0;
        way_d   = '0;
      end
    endcase
    done_d    = (state_d == FLUSH_DONE);
    ongoing_d = (state_d == FLUSH_WALK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FLUSH_IDLE;
      set_q     <= '0;
      way_q     <= '0;
      done_q    <= 1'b0;
      ongoing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      way_q     <= way_d;
      done_q    <= done_d;
      ongoing_q <= ongoing_d;
    end
  end

  assign flush_set     = set_q;
  assign flush_way     = way_q;
  assign flush_done    = done_q;
  assign ongoing_flush = ongoing_q;

endmodule

// File: rtl/l2_global_regs.sv
// Global-state register bank for the Spandex L2 controller: MSHR accounting,
// stall/status flags and the flush walker.
module l2_global_regs
  import l2_global_pkg::*;
#(
  parameter int N_MSHR  = 16,
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8,
  localparam int MSHR_W = bits_min1(N_MSHR),
  localparam int SET_W  = bits_min1(L2_SETS),
  localparam int WAY_W  = bits_min1(L2_WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mshr_alloc,
  input  logic              mshr_free,
  input  logic [MSHR_W-1:0] mshr_i,
  output logic [MSHR_W:0]   mshr_cnt,
  output logic              mshr_full,
  output logic              mshr_empty,
  output logic              mshr_err,
  input  logic              set_evict_stall,
  input  logic              clr_evict_stall,
  output logic              evict_stall,
  input  logic              set_set_conflict,
  input  logic              clr_set_conflict,
  output logic              set_conflict,
  input  logic              set_fwd_stall,
  input  logic              clr_fwd_stall,
  input  logic [MSHR_W-1:0] fwd_stall_i_wr_data,
  output logic              fwd_stall,
  output logic [MSHR_W-1:0] fwd_stall_i,
  output logic              fwd_stall_ended,
  input  logic              clr_fwd_stall_ended,
  input  logic              set_ongoing_atomic,
  input  logic              clr_ongoing_atomic,
  output logic              ongoing_atomic,
  input  logic              flush_start,
  input  logic              flush_step,
  input  logic              flush_abort,
  output logic [SET_W-1:0]  flush_set,
  output logic [WAY_W-1:0]  flush_way,
  output logic              ongoing_flush,
  output logic              flush_done
);

  localparam logic [MSHR_W:0] CNT_MAX = N_MSHR[MSHR_W:0];
  localparam logic [MSHR_W:0] CNT_ONE = {{MSHR_W{1'b0}}, 1'b1};

  logic [MSHR_W:0]   mshr_cnt_d, mshr_cnt_q;
  logic              mshr_err_d, mshr_err_q;
  logic              evict_stall_d, evict_stall_q;
  logic              set_conflict_d, set_conflict_q;
  logic              fwd_stall_d, fwd_stall_q;
  logic [MSHR_W-1:0] fwd_stall_i_d, fwd_stall_i_q;
  logic              fwd_stall_ended_d, fwd_stall_ended_q;
  logic              ongoing_atomic_d, ongoing_atomic_q;

  // Simultaneous alloc and free cancel out; out-of-range moves hold and flag.
  always_comb begin
    mshr_cnt_d = mshr_cnt_q;
    mshr_err_d = mshr_err_q;
    if (mshr_alloc && !mshr_free) begin
      if (mshr_cnt_q == '0) begin
        mshr_err_d = 1'b1;
      end else begin
        mshr_cnt_d = mshr_cnt_q - CNT_ONE;
      end
    end else if (mshr_free && !mshr_alloc) begin
      if (mshr_cnt_q == CNT_MAX) begin
        mshr_err_d = 1'b1;
      end else begin
        mshr_cnt_d = mshr_cnt_q + CNT_ONE;
      end
    end else begin
      mshr_cnt_d = mshr_cnt_q;
    end
  end

  always_comb begin
    evict_stall_d    = sc_next(evict_stall_q, set_evict_stall, clr_evict_stall);
    set_conflict_d   = sc_next(set_conflict_q, set_set_conflict, clr_set_conflict);
    fwd_stall_d      = sc_next(fwd_stall_q, set_fwd_stall, clr_fwd_stall);
    ongoing_atomic_d = sc_next(ongoing_atomic_q, set_ongoing_atomic, clr_ongoing_atomic);
    if (set_fwd_stall) begin
      fwd_stall_i_d = fwd_stall_i_wr_data;
    end else begin
      fwd_stall_i_d = fwd_stall_i_q;
    end
    // A new stall re-arms the tracker; matching uses the already-registered index.
    if (clr_fwd_stall_ended || set_fwd_stall) begin
      fwd_stall_ended_d = 1'b0;
    end else if (mshr_free && fwd_stall_q && (mshr_i == fwd_stall_i_q)) begin
      fwd_stall_ended_d = 1'b1;
    end else begin
      fwd_stall_ended_d = fwd_stall_ended_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mshr_cnt_q        <= CNT_MAX;
      mshr_err_q        <= 1'b0;
      evict_stall_q     <= 1'b0;
      set_conflict_q    <= 1'b0;
      fwd_stall_q       <= 1'b0;
      fwd_stall_i_q     <= '0;
      fwd_stall_ended_q <= 1'b0;
      ongoing_atomic_q  <= 1'b0;
    end else begin
      mshr_cnt_q        <= mshr_cnt_d;
      mshr_err_q        <= mshr_err_d;
      evict_stall_q     <= evict_stall_d;
      set_conflict_q    <= set_conflict_d;
      fwd_stall_q       <= fwd_stall_d;
      fwd_stall_i_q     <= fwd_stall_i_d;
      fwd_stall_ended_q <= fwd_stall_ended_d;
      ongoing_atomic_q  <= ongoing_atomic_d;
    end
  end

  assign mshr_cnt        = mshr_cnt_q;
  assign mshr_full       = (mshr_cnt_q == '0);
  assign mshr_empty      = (mshr_cnt_q == CNT_MAX);
  assign mshr_err        = mshr_err_q;
  assign evict_stall     = evict_stall_q;
  assign set_conflict    = set_conflict_q;
  assign fwd_stall       = fwd_stall_q;
  assign fwd_stall_i     = fwd_stall_i_q;
  assign fwd_stall_ended = fwd_stall_ended_q;
  assign ongoing_atomic  = ongoing_atomic_q;

  l2_flush_walker #(
    .L2_SETS (L2_SETS),
    .L2_WAYS (L2_WAYS)
  ) u_walker (
    .clk           (clk),
    .rst           (rst),
    .flush_start   (flush_start),
    .flush_step    (flush_step),
    .flush_abort   (flush_abort),
    .flush_set     (flush_set),
    .flush_way     (flush_way),
    .ongoing_flush (ongoing_flush),
    .flush_done    (flush_done)
  );

endmodule
